// File: rtl/fpadd_rr_scheduler_pkg.sv
// Shared constants and state type for the round-robin FP adder scheduler.
package fpadd_sched_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int EXP_LSB = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Biased exponent field of a single-precision word.
  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[EXP_LSB +: EXP_W];
  endfunction

endpackage

// File: rtl/fpadd_rr_scheduler_if.sv
// Requester, shared-adder and response signals of the FP adder scheduler.
// slave = scheduler side, master = requesters/adder/consumer side.
interface fpadd_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import fpadd_sched_pkg::*;

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [FP_W*NUM_REQ-1:0] req_a;
  logic [FP_W*NUM_REQ-1:0] req_b;
  logic [FP_W-1:0]         add_a;
  logic [FP_W-1:0]         add_b;
  logic [FP_W-1:0]         add_sum;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [FP_W-1:0]         rsp_sum;
  logic                    busy;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
  );

endinterface

// File: rtl/fpadd_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic found;
  int   idx;

  // Scan upward from ptr; the first pending request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_rr_scheduler.sv
// Shares one combinational FP adder among NUM_REQ requesters, round-robin.
// Optional macro FPADD_SCHED_ZERO_BYPASS_EN: replace the adder result when
// either operand has a zero exponent (zero/subnormal), which the adder can't handle.
//
// state | meaning
// IDLE  | arbitrating; req_ready shows the one-hot grant
// ISSUE | latched operands on add_a/add_b; sum captured at end of cycle
// RESP  | rsp_valid high, waiting for rsp_ready
module fpadd_rr_scheduler
  import fpadd_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fpadd_rr_scheduler_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      id_q;
  logic [FP_W-1:0]     op_a_q, op_b_q, sum_q;
  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_idx;
  logic                accept;
  logic                done;
  logic [FP_W-1:0]     result;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .en        (state_q == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = (state_q == IDLE) && |(bus.req_valid & grant);
  assign done   = (state_q == RESP) && bus.rsp_ready;

`ifdef FPADD_SCHED_ZERO_BYPASS_EN
  // Substitute the result for zero/subnormal operands.
  always_comb begin
    result = bus.add_sum;
    if (fp_exp(op_a_q) == '0 && fp_exp(op_b_q) == '0)
      result = {op_a_q[FP_W-1] & op_b_q[FP_W-1], {(FP_W-1){1'b0}}};
    else if (fp_exp(op_a_q) == '0)
      result = op_b_q;
    else if (fp_exp(op_b_q) == '0)
      result = op_a_q;
  end
`else
  assign result = bus.add_sum;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/ID capture on accept, sum capture in ISSUE, pointer advance on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      id_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q  <= '0;
    end else begin
      if (accept) begin
        op_a_q <= bus.req_a[FP_W*int'(grant_idx) +: FP_W];
        op_b_q <= bus.req_b[FP_W*int'(grant_idx) +: FP_W];
        id_q   <= grant_idx;
      end
      if (state_q == ISSUE) sum_q <= result;
      if (done) ptr_q <= (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_a     = op_a_q;
  assign bus.add_b     = op_b_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
